// File: rtl/core_pkg.sv
// Shared types for the 16-bit mini core: words, opcodes and sequencer states.
package core_pkg;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  op_t;

  localparam op_t OP_R = 3'd0;
  localparam op_t OP_I = 3'd1;
  localparam op_t OP_L = 3'd2;
  localparam op_t OP_S = 3'd3;
  localparam op_t OP_B = 3'd4;
  localparam op_t OP_J = 3'd5;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } ctrl_state_t;

  // Opcodes 110 and 111 have no defined instruction class.
  function automatic logic op_legal(input op_t op);
    return (op <= OP_J);
  endfunction

endpackage

// File: rtl/bus_wdog.sv
// Bus watchdog: counts request cycles without ready and flags a timeout on
// the last permitted wait cycle, so the owner can trap instead of waiting.
module bus_wdog #(
  parameter int unsigned BUS_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic req,
  input  logic ready,
  output logic timeout_o
);

  localparam logic [7:0] LAST_WAIT = 8'(BUS_TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: restart on every phase change, otherwise count stalled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (req && !ready) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Ready on the last permitted wait cycle still completes normally.
  assign timeout_o = req && !ready && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the 16-bit mini core: owns PC and IR, fetches
// over a req/ready handshake and steps ALU / memory / writeback phases.
module core_seq_ctrl import core_pkg::*; #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned BUS_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  input  logic        imem_ready_i,
  input  logic [15:0] imem_rdata_i,
  output logic [15:0] pc_o,
  output logic [15:0] instr_o,
  input  logic [2:0]  op_i,
  input  logic        branch_taken_i,
  input  logic [15:0] target_i,
  output logic        alu_en_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_ready_i,
  output logic        rf_we_o,
  output logic [15:0] retired_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic        halt_o
);

  ctrl_state_t state_q, state_d;
  word_t       pc_q, pc_d;
  word_t       ir_q, ir_d;
  op_t         op_q, op_d;
  word_t       retired_q, retired_d;
  logic        illegal_q, illegal_d;
  logic        bus_err_q, bus_err_d;
  logic        halt_q, halt_d;
  logic        imem_req_q, imem_req_d;
  logic        alu_en_q, alu_en_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic        rf_we_q, rf_we_d;
  logic        retire;
  logic        in_fetch, in_mem, timeout;

  assign in_fetch = (state_q == FETCH);
  assign in_mem   = (state_q == MEM);

  bus_wdog #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_d != state_q),
    .req       (in_fetch || in_mem),
    .ready     (in_fetch ? imem_ready_i : dmem_ready_i),
    .timeout_o (timeout)
  );

  // Sequencer next-state, PC/IR/retire updates and next-cycle strobes.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    retire    = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_ready_i) begin
          ir_d    = imem_rdata_i;
          state_d = DECODE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = TRAP;
        end
      end
      DECODE: begin
        op_d = op_i;
        if (!op_legal(op_i)) begin
          illegal_d = 1'b1;
          state_d   = TRAP;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          OP_R, OP_I: state_d = WB;
          OP_L, OP_S: state_d = MEM;
          OP_B: begin
            pc_d    = branch_taken_i ? target_i : pc_q + 16'd1;
            retire  = 1'b1;
            state_d = FETCH;
          end
          OP_J: begin
            pc_d    = target_i;
            retire  = 1'b1;
            state_d = FETCH;
          end
          default: state_d = TRAP;
        endcase
      end
      MEM: begin
        if (dmem_ready_i) begin
          if (op_q == OP_S) begin
            pc_d    = pc_q + 16'd1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = TRAP;
        end
      end
      WB: begin
        pc_d    = pc_q + 16'd1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = TRAP;
    endcase
    retired_d  = retired_q + 16'(retire);
    halt_d     = (state_d == TRAP);
    imem_req_d = (state_d == FETCH);
    alu_en_d   = (state_d == EXEC);
    dmem_req_d = (state_d == MEM);
    dmem_we_d  = (state_d == MEM) && (op_q == OP_S);
    rf_we_d    = (state_d == WB);
  end

  // State and registered outputs; reset lands in FETCH with the request armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      op_q       <= OP_R;
      retired_q  <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      halt_q     <= 1'b0;
      imem_req_q <= 1'b1;
      alu_en_q   <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      op_q       <= op_d;
      retired_q  <= retired_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
      halt_q     <= halt_d;
      imem_req_q <= imem_req_d;
      alu_en_q   <= alu_en_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_we_q    <= rf_we_d;
    end
  end

  // Strobes are forced low for the whole time rst is held.
  assign imem_req_o = imem_req_q && !rst;
  assign alu_en_o   = alu_en_q   && !rst;
  assign dmem_req_o = dmem_req_q && !rst;
  assign dmem_we_o  = dmem_we_q  && !rst;
  assign rf_we_o    = rf_we_q    && !rst;

  assign pc_o      = pc_q;
  assign instr_o   = ir_q;
  assign retired_o = retired_q;
  assign illegal_o = illegal_q;
  assign bus_err_o = bus_err_q;
  assign halt_o    = halt_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: directed vector table, hand-written
// reset/trap sequences and randomized instructions against a latency model.
module tb_core_seq_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic        imem_ready_i = 1'b0;
  logic [15:0] imem_rdata_i = '0;
  logic [15:0] pc_o;
  logic [15:0] instr_o;
  logic [2:0]  op_i;
  logic        branch_taken_i = 1'b0;
  logic [15:0] target_i = '0;
  logic        alu_en_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_ready_i = 1'b0;
  logic        rf_we_o;
  logic [15:0] retired_o;
  logic        illegal_o;
  logic        bus_err_o;
  logic        halt_o;

  core_seq_ctrl #(.RESET_PC(16'h0000), .BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .instr_o(instr_o), .op_i(op_i),
    .branch_taken_i(branch_taken_i), .target_i(target_i),
    .alu_en_o(alu_en_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_ready_i(dmem_ready_i), .rf_we_o(rf_we_o), .retired_o(retired_o),
    .illegal_o(illegal_o), .bus_err_o(bus_err_o), .halt_o(halt_o)
  );

  // Combinational decoder stand-in: opcode is IR[2:0].
  assign op_i = instr_o[2:0];

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_pc;
  logic [15:0] m_ret;
  bit          m_trap;

  int a_cyc, a_alu, a_dreq, a_dwe, a_rf, a_ireq;
  bit a_bad, a_done;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ret;
    int cyc; int ireq; int alu; int dreq; int dwe; int rf;
    bit ill; bit berr; bit halt;
  } exp_t;

  typedef struct {
    logic [15:0] instr; int iw; int dw; bit tk; logic [15:0] tgt;
    logic [15:0] pc; logic [15:0] ret; int cyc; int dreq; int rf;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Instruction-level outcome from the class latency rules and wait counts.
  function automatic exp_t model(input logic [15:0] pc, input logic [15:0] ret,
                                 input logic [15:0] instr, input int iw, input int dw,
                                 input bit tk, input logic [15:0] tgt);
    exp_t e;
    int op;
    int fetch;
    op = int'(instr[2:0]);
    fetch = iw + 1;
    e.pc = pc; e.ret = ret;
    e.cyc = 0; e.ireq = 0; e.alu = 0; e.dreq = 0; e.dwe = 0; e.rf = 0;
    e.ill = 0; e.berr = 0; e.halt = 0;
    if (iw >= TO) begin
      e.cyc = TO; e.ireq = TO; e.berr = 1; e.halt = 1;
      return e;
    end
    e.ireq = fetch;
    if (op >= 6) begin
      e.cyc = fetch + 1; e.ill = 1; e.halt = 1;
      return e;
    end
    e.alu = 1;
    if (op == 0 || op == 1) begin
      e.cyc = fetch + 3; e.rf = 1; e.pc = pc + 16'd1; e.ret = ret + 16'd1;
    end else if (op == 2 || op == 3) begin
      if (dw >= TO) begin
        e.dreq = TO; e.cyc = fetch + 2 + TO; e.berr = 1; e.halt = 1;
      end else begin
        e.dreq = dw + 1;
        e.rf = (op == 2) ? 1 : 0;
        e.cyc = fetch + 2 + e.dreq + e.rf;
        e.pc = pc + 16'd1; e.ret = ret + 16'd1;
      end
      e.dwe = (op == 3) ? e.dreq : 0;
    end else begin
      e.cyc = fetch + 2; e.ret = ret + 16'd1;
      e.pc = (op == 5 || tk) ? tgt : pc + 16'd1;
    end
    return e;
  endfunction

  // Drives one instruction's handshakes from the first FETCH cycle until the
  // next fetch starts or the core halts; entered and left at a falling edge.
  task automatic run_instr(input logic [15:0] instr, input int iw, input int dw,
                           input bit tk, input logic [15:0] tgt);
    int ic, dc;
    bit fetched;
    ic = 0; dc = 0; fetched = 0;
    a_cyc = 0; a_alu = 0; a_dreq = 0; a_dwe = 0; a_rf = 0; a_ireq = 0;
    a_bad = 0; a_done = 0;
    for (int k = 0; k < 600; k++) begin
      if (halt_o || (fetched && imem_req_o)) begin
        a_done = 1;
        break;
      end
      if ($countones({imem_req_o, alu_en_o, dmem_req_o, rf_we_o}) > 1 ||
          (dmem_we_o && !dmem_req_o)) a_bad = 1;
      if (imem_req_o) a_ireq++;
      if (alu_en_o)   a_alu++;
      if (dmem_req_o) a_dreq++;
      if (dmem_we_o)  a_dwe++;
      if (rf_we_o)    a_rf++;
      imem_rdata_i   = instr;
      branch_taken_i = tk;
      target_i       = tgt;
      imem_ready_i   = imem_req_o && (ic == iw);
      dmem_ready_i   = dmem_req_o && (dc == dw);
      if (imem_ready_i) fetched = 1;
      if (imem_req_o) ic++;
      if (dmem_req_o) dc++;
      a_cyc++;
      @(negedge clk);
    end
    imem_ready_i = 1'b0;
    dmem_ready_i = 1'b0;
  endtask

  task automatic run_one(input string tg, input logic [15:0] instr, input int iw,
                         input int dw, input bit tk, input logic [15:0] tgt);
    exp_t e;
    e = model(m_pc, m_ret, instr, iw, dw, tk, tgt);
    run_instr(instr, iw, dw, tk, tgt);
    chk({tg, "_done"},    a_done, 1);
    chk({tg, "_cycles"},  a_cyc, e.cyc);
    chk({tg, "_ireq"},    a_ireq, e.ireq);
    chk({tg, "_alu"},     a_alu, e.alu);
    chk({tg, "_dreq"},    a_dreq, e.dreq);
    chk({tg, "_dwe"},     a_dwe, e.dwe);
    chk({tg, "_rfwe"},    a_rf, e.rf);
    chk({tg, "_overlap"}, a_bad, 0);
    chk({tg, "_pc"},      pc_o, e.pc);
    chk({tg, "_retired"}, retired_o, e.ret);
    chk({tg, "_illegal"}, illegal_o, e.ill);
    chk({tg, "_buserr"},  bus_err_o, e.berr);
    chk({tg, "_halt"},    halt_o, e.halt);
    if (iw < TO) chk({tg, "_instr"}, instr_o, instr);
    m_pc = e.pc;
    m_ret = e.ret;
    m_trap = e.halt;
  endtask

  // Holds rst for two edges, then checks the reset state with the request armed.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_ready_i = 1'b0;
    dmem_ready_i = 1'b0;
    #1;
    chk("rst_strobes", {imem_req_o, alu_en_o, dmem_req_o, dmem_we_o, rf_we_o}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_pc", pc_o, 16'h0000);
    chk("rst_retired", retired_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_flags", {illegal_o, bus_err_o, halt_o}, 0);
    chk("rst_imem_req", imem_req_o, 1);
    chk("rst_other_strobes", {alu_en_o, dmem_req_o, dmem_we_o, rf_we_o}, 0);
    m_pc = 16'h0000;
    m_ret = 16'h0000;
    m_trap = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [15:0] ins;
    int iw, dw;
    bit bad;

    tbl[0]  = '{16'h0000, 0,  0, 0, 16'h0000, 16'h0001, 16'd1,  4,  0, 1};
    tbl[1]  = '{16'h0001, 2,  0, 0, 16'h0000, 16'h0002, 16'd2,  6,  0, 1};
    tbl[2]  = '{16'h0002, 0,  3, 0, 16'h0000, 16'h0003, 16'd3,  8,  4, 1};
    tbl[3]  = '{16'h0003, 0,  3, 0, 16'h0000, 16'h0004, 16'd4,  7,  4, 0};
    tbl[4]  = '{16'h0004, 0,  0, 1, 16'h0040, 16'h0040, 16'd5,  3,  0, 0};
    tbl[5]  = '{16'h0004, 0,  0, 0, 16'h0999, 16'h0041, 16'd6,  3,  0, 0};
    tbl[6]  = '{16'h0005, 0,  0, 0, 16'h1234, 16'h1234, 16'd7,  3,  0, 0};
    tbl[7]  = '{16'h0002, 0,  0, 0, 16'h0000, 16'h1235, 16'd8,  5,  1, 1};
    tbl[8]  = '{16'h0003, 0,  0, 0, 16'h0000, 16'h1236, 16'd9,  4,  1, 0};
    tbl[9]  = '{16'h0005, 0,  0, 1, 16'hFFFF, 16'hFFFF, 16'd10, 3,  0, 0};
    tbl[10] = '{16'hABC0, 0,  0, 0, 16'h0000, 16'h0000, 16'd11, 4,  0, 1};
    tbl[11] = '{16'h0001, 14, 0, 0, 16'h0000, 16'h0001, 16'd12, 18, 0, 1};
    tbl[12] = '{16'h0002, 0, 14, 0, 16'h0000, 16'h0002, 16'd13, 19, 15, 1};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      run_one($sformatf("vec%0d", i), tbl[i].instr, tbl[i].iw, tbl[i].dw,
              tbl[i].tk, tbl[i].tgt);
      chk($sformatf("vec%0d_tbl_pc", i), pc_o, tbl[i].pc);
      chk($sformatf("vec%0d_tbl_retired", i), retired_o, tbl[i].ret);
      chk($sformatf("vec%0d_tbl_cycles", i), a_cyc, tbl[i].cyc);
      chk($sformatf("vec%0d_tbl_dreq", i), a_dreq, tbl[i].dreq);
      chk($sformatf("vec%0d_tbl_rfwe", i), a_rf, tbl[i].rf);
    end

    // Reset in the middle of a stalled load; a late dmem ready must be ignored.
    imem_rdata_i = 16'h0002;
    imem_ready_i = 1'b1;
    @(negedge clk);
    imem_ready_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("midmem_dreq", dmem_req_o, 1);
    chk("midmem_dwe", dmem_we_o, 0);
    rst = 1'b1;
    #1;
    chk("midmem_dreq_rst", dmem_req_o, 0);
    @(negedge clk);
    chk("midmem_pc", pc_o, 16'h0000);
    chk("midmem_retired", retired_o, 0);
    chk("midmem_strobes", {imem_req_o, alu_en_o, dmem_req_o, rf_we_o}, 0);
    rst = 1'b0;
    dmem_ready_i = 1'b1;
    #1;
    chk("midmem_refetch", imem_req_o, 1);
    @(negedge clk);
    chk("midmem_late_ready", {imem_req_o, alu_en_o, dmem_req_o, rf_we_o}, 4'b1000);
    chk("midmem_ir", instr_o, 0);
    dmem_ready_i = 1'b0;
    m_pc = 16'h0000;
    m_ret = 16'h0000;
    run_one("post_rst", 16'h0001, 0, 0, 0, 16'h0000);

    // Illegal opcode: terminal trap with no further fetch until reset.
    run_one("illegal", 16'h0006, 0, 0, 0, 16'h0000);
    bad = 0;
    imem_ready_i = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (imem_req_o || alu_en_o || !halt_o || !illegal_o) bad = 1;
    end
    imem_ready_i = 1'b0;
    chk("illegal_terminal", bad, 0);
    do_reset();

    // Fetch that never completes: bus error after the full wait budget.
    run_one("fetch_to", 16'h0000, TO, 0, 0, 16'h0000);
    chk("fetch_to_cycles_abs", a_cyc, 15);
    chk("fetch_to_req_dropped", imem_req_o, 0);
    do_reset();

    // Randomized instruction stream, including occasional traps.
    for (int n = 0; n < 150; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 24) == 0) ins[2:0] = 3'($urandom_range(6, 7));
      else ins[2:0] = 3'($urandom_range(0, 5));
      iw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(13, 16)) : int'($urandom_range(0, 2));
      dw = ($urandom_range(0, 9) == 0)  ? int'($urandom_range(13, 16)) : int'($urandom_range(0, 3));
      run_one($sformatf("rnd%0d", n), ins, iw, dw, 1'($urandom), 16'($urandom));
      if (m_trap) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit mini core.
- Owns the PC and instruction register (IR), and drives instruction fetch over a req/ready handshake.
- Presents IR to the combinational instruction decoder and reads back its opcode field.
- Steps the ALU, data-memory and register-file write phases per instruction class, and traps on illegal opcodes or bus timeouts.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- BUS_TIMEOUT, 15, maximum wait cycles for imem/dmem ready before a bus-error trap (legal range 1..255).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_o  out  1  instruction fetch request.
- imem_ready_i  in  1  fetch data valid this cycle.
- imem_rdata_i  in  16  fetched instruction.
- pc_o  out  16  current PC, word address; also the fetch address.
- instr_o  out  16  latched IR, feeds the decoder.
- op_i  in  3  opcode returned by the decoder (IR[2:0]).
- branch_taken_i  in  1  branch condition from the ALU, valid in EXEC.
- target_i  in  16  branch/jump target, valid in EXEC.
- alu_en_o  out  1  ALU operation strobe.
- dmem_req_o  out  1  data-memory request.
- dmem_we_o  out  1  data-memory write (store).
- dmem_ready_i  in  1  data-memory access complete.
- rf_we_o  out  1  register-file write enable.
- retired_o  out  16  retired-instruction count.
- illegal_o  out  1  sticky: illegal opcode trap.
- bus_err_o  out  1  sticky: bus timeout trap.
- halt_o  out  1  core halted in TRAP.

Behaviour:
- Reset (synchronous, active-high) takes effect at the next edge:
  - state <= FETCH, pc <= RESET_PC, IR <= 0, retired <= 0, wait counter <= 0.
  - illegal, bus_err and halt all cleared.
  - All strobes (imem_req_o, alu_en_o, dmem_req_o, dmem_we_o, rf_we_o) are 0 while rst is high.
  - Reset mid-access drops the request; a late ready is ignored.
- Opcodes:
  - 000 R, 001 I, 010 L (load), 011 S (store), 100 B (branch), 101 J (jump).
  - 110 and 111 are illegal.
- FETCH: imem_req_o=1 held until imem_ready_i.
  - On ready: IR <= imem_rdata_i, go to DECODE.
  - Ready in the same cycle as the request is legal (zero wait).
- DECODE: one cycle; the decoder settles on IR and op_i is sampled.
  - Illegal opcode: illegal_o <= 1, go to TRAP.
  - Otherwise go to EXEC.
- EXEC: alu_en_o=1 for exactly one cycle.
  - R/I: go to WB.
  - L/S: go to MEM.
  - B: pc <= branch_taken_i ? target_i : pc+1; retire; go to FETCH.
  - J: pc <= target_i; retire; go to FETCH.
- MEM: dmem_req_o=1, dmem_we_o=(op==S), both held until dmem_ready_i.
  - L: go to WB.
  - S: pc <= pc+1; retire; go to FETCH.
- WB: rf_we_o=1 for one cycle; pc <= pc+1; retire; go to FETCH.
- TRAP: halt_o=1, all strobes 0. Terminal until rst.
- Latency with zero-wait memory:
  - R/I: 4 cycles.
  - L: 5 cycles.
  - S: 4 cycles.
  - B/J: 3 cycles.
- Wait counter (8-bit):
  - Clears on each entry to FETCH or MEM.
  - Increments every cycle the request is high without ready.
  - If the counter reaches BUS_TIMEOUT with ready still low: bus_err_o <= 1, go to TRAP, and the request drops.
  - Ready on the cycle the counter equals BUS_TIMEOUT-1 completes normally.
- Arithmetic:
  - pc+1 wraps 16'hFFFF -> 16'h0000.
  - retired_o wraps 16'hFFFF -> 0.
  - Retire increments by exactly 1 per completed instruction.
- instr_o is stable from FETCH completion until the next FETCH completion.
- dmem_we_o is never high without dmem_req_o.
- At most one of alu_en_o, dmem_req_o, rf_we_o, imem_req_o is high per cycle.

Decomposition:
- Shared package core_pkg:
  - opcode constants OP_R..OP_J as a 3-bit typedef op_t.
  - state enum ctrl_state_t {FETCH, DECODE, EXEC, MEM, WB, TRAP}.
  - 16-bit word typedef.
- One natural sub-module: bus_wdog (wait counter plus timeout compare, parameterised by BUS_TIMEOUT), shared by the FETCH and MEM phases.

Test Plan:
- Zero-wait R-type 16'h0000 at pc 0 -> imem_req 1 cycle, alu_en in cycle 3, rf_we in cycle 4, pc=1, retired=1.
- Load with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, then rf_we 1 cycle, pc+1, retired+1. Store: same delay, dmem_we=1, no rf_we.
- Branch with branch_taken_i=1, target 16'h0040 -> pc=16'h0040 after 3 cycles. Repeat with taken=0 -> pc+1. Jump to 16'h1234 -> pc=16'h1234.
- Fetch returns 16'h0006 (op 110) -> illegal_o=1 and halt_o=1 after DECODE; no further imem_req until rst; rst clears both.
- imem_ready_i held 0 with BUS_TIMEOUT=15 -> bus_err_o=1 and TRAP after 15 wait cycles. Ready at wait cycle 14 -> normal completion, no error.
- Wrap and reset: pc=16'hFFFF R-type -> pc=0. rst asserted during MEM wait -> next cycle state FETCH, pc=RESET_PC, dmem_req=0, retired=0.
